// File: rtl/alu_issue_if.sv
// Request/result handshake bundle between decode, the ALU issue stage and writeback.
// The stage uses the slave view; the producer/consumer side uses the master view.
interface alu_issue_if #(
    parameter int DATA_W = 32
) ();
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        in_funct3;
    logic              in_funct7b5;
    logic              in_is_imm;
    logic [DATA_W-1:0] in_a;
    logic [DATA_W-1:0] in_b;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_result;
    logic              out_z;
    logic              out_c;
    logic              out_n;

    modport slave (
        input  in_valid, in_funct3, in_funct7b5, in_is_imm, in_a, in_b, out_ready,
        output in_ready, out_valid, out_result, out_z, out_c, out_n
    );

    modport master (
        output in_valid, in_funct3, in_funct7b5, in_is_imm, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_result, out_z, out_c, out_n
    );
endinterface

// File: rtl/alu_issue_stage.sv
// Handshaked RV32I OP/OP-IMM issue stage: decodes funct3/funct7b5 into ALU selects,
// drives a combinational ALU from registers and returns its result on a valid/ready port.
module alu_issue_stage #(
    parameter int DATA_W  = 32,
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    alu_issue_if.slave         bus,
    output logic [DATA_W-1:0]  srcA,
    output logic [DATA_W-1:0]  srcB,
    output logic               sel_a,
    output logic               sel_comp,
    output logic [1:0]         sel_s,
    output logic [1:0]         sel_l,
    output logic [1:0]         sel_exec_out,
    input  logic [DATA_W-1:0]  exec_out,
    input  logic               z,
    input  logic               c,
    input  logic               n,
    output logic [COUNT_W-1:0] op_count
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   src_a_q, src_a_d, src_b_q, src_b_d;
    logic                sel_a_q, sel_a_d, sel_comp_q, sel_comp_d;
    logic [1:0]          sel_s_q, sel_s_d, sel_l_q, sel_l_d, sel_exec_q, sel_exec_d;
    logic [DATA_W-1:0]   result_q, result_d;
    logic                z_q, z_d, c_q, c_d, n_q, n_d;
    logic [COUNT_W-1:0]  op_count_q, op_count_d;

    logic                in_ready_s;
    logic                accept_s;
    logic [DATA_W-1:0]   dec_b_s;
    logic                dec_sel_a_s, dec_sel_comp_s;
    logic [1:0]          dec_sel_s_s, dec_sel_l_s, dec_exec_s;

    assign in_ready_s = (state_q == IDLE) | ((state_q == DONE) & bus.out_ready);
    assign accept_s   = bus.in_valid & in_ready_s;

    // Decode funct3/funct7b5 into ALU selects; fields a given op does not use stay 0.
    always_comb begin
        dec_b_s        = bus.in_b;
        dec_sel_a_s    = 1'b0;
        dec_sel_comp_s = 1'b0;
        dec_sel_s_s    = 2'b00;
        dec_sel_l_s    = 2'b00;
        dec_exec_s     = 2'b00;
        case (bus.in_funct3)
            3'b000: dec_sel_a_s = bus.in_funct7b5 & ~bus.in_is_imm;
            3'b001: begin
                dec_b_s    = {{(DATA_W-5){1'b0}}, bus.in_b[4:0]};
                dec_exec_s = 2'b11;
            end
            3'b010: begin
                dec_sel_a_s    = 1'b1;
                dec_sel_comp_s = 1'b1;
                dec_exec_s     = 2'b01;
            end
            3'b011: begin
                dec_sel_a_s = 1'b1;
                dec_exec_s  = 2'b01;
            end
            3'b100: dec_exec_s = 2'b10;
            3'b101: begin
                // funct7b5 selects SRA for both SRA and SRAI.
                dec_b_s     = {{(DATA_W-5){1'b0}}, bus.in_b[4:0]};
                dec_sel_s_s = {1'b1, bus.in_funct7b5};
                dec_exec_s  = 2'b11;
            end
            3'b110: begin
                dec_sel_l_s = 2'b01;
                dec_exec_s  = 2'b10;
            end
            3'b111: begin
                dec_sel_l_s = 2'b10;
                dec_exec_s  = 2'b10;
            end
            default: dec_exec_s = 2'b00;
        endcase
    end

    // Next state, operand/select capture on acceptance, result capture in EXEC, handoff count.
    always_comb begin
        state_d    = state_q;
        result_d   = result_q;
        z_d        = z_q;
        c_d        = c_q;
        n_d        = n_q;
        op_count_d = op_count_q;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    state_d = EXEC;
                end else begin
                    state_d = IDLE;
                end
            end
            EXEC: begin
                result_d = exec_out;
                z_d      = z;
                c_d      = c;
                n_d      = n;
                state_d  = DONE;
            end
            DONE: begin
                if (bus.out_ready) begin
                    op_count_d = op_count_q + COUNT_W'(1);
                    if (bus.in_valid) begin
                        state_d = EXEC;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (accept_s) begin
            src_a_d    = bus.in_a;
            src_b_d    = dec_b_s;
            sel_a_d    = dec_sel_a_s;
            sel_comp_d = dec_sel_comp_s;
            sel_s_d    = dec_sel_s_s;
            sel_l_d    = dec_sel_l_s;
            sel_exec_d = dec_exec_s;
        end else begin
            src_a_d    = src_a_q;
            src_b_d    = src_b_q;
            sel_a_d    = sel_a_q;
            sel_comp_d = sel_comp_q;
            sel_s_d    = sel_s_q;
            sel_l_d    = sel_l_q;
            sel_exec_d = sel_exec_q;
        end
    end

    // State and datapath registers; reset discards any in-flight result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            src_a_q    <= '0;
            src_b_q    <= '0;
            sel_a_q    <= 1'b0;
            sel_comp_q <= 1'b0;
            sel_s_q    <= 2'b00;
            sel_l_q    <= 2'b00;
            sel_exec_q <= 2'b00;
            result_q   <= '0;
            z_q        <= 1'b0;
            c_q        <= 1'b0;
            n_q        <= 1'b0;
            op_count_q <= '0;
        end else begin
            state_q    <= state_d;
            src_a_q    <= src_a_d;
            src_b_q    <= src_b_d;
            sel_a_q    <= sel_a_d;
            sel_comp_q <= sel_comp_d;
            sel_s_q    <= sel_s_d;
            sel_l_q    <= sel_l_d;
            sel_exec_q <= sel_exec_d;
            result_q   <= result_d;
            z_q        <= z_d;
            c_q        <= c_d;
            n_q        <= n_d;
            op_count_q <= op_count_d;
        end
    end

    assign bus.in_ready   = in_ready_s;
    assign bus.out_valid  = (state_q == DONE);
    assign bus.out_result = result_q;
    assign bus.out_z      = z_q;
    assign bus.out_c      = c_q;
    assign bus.out_n      = n_q;
    assign srcA           = src_a_q;
    assign srcB           = src_b_q;
    assign sel_a          = sel_a_q;
    assign sel_comp       = sel_comp_q;
    assign sel_s          = sel_s_q;
    assign sel_l          = sel_l_q;
    assign sel_exec_out   = sel_exec_q;
    assign op_count       = op_count_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage with a behavioural RV32I ALU closing the loop.
// A narrow op counter keeps the wrap-around check short.
module tb_alu_issue_stage;
    localparam int DATA_W  = 32;
    localparam int COUNT_W = 4;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [DATA_W-1:0]  srcA, srcB, exec_out;
    logic               sel_a, sel_comp, z, c, n;
    logic [1:0]         sel_s, sel_l, sel_exec_out;
    logic [COUNT_W-1:0] op_count;
    logic [COUNT_W-1:0] exp_cnt;
    int                 checks = 0;
    int                 errors = 0;

    alu_issue_if #(.DATA_W(DATA_W)) bus ();

    alu_issue_stage #(.DATA_W(DATA_W), .COUNT_W(COUNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .srcA(srcA), .srcB(srcB), .sel_a(sel_a), .sel_comp(sel_comp),
        .sel_s(sel_s), .sel_l(sel_l), .sel_exec_out(sel_exec_out),
        .exec_out(exec_out), .z(z), .c(c), .n(n), .op_count(op_count)
    );

    always #5 clk = ~clk;

    // Reference ALU driven by the stage's registered operands and selects.
    logic [DATA_W:0] sum33;
    always_comb begin
        sum33    = '0;
        exec_out = '0;
        case (sel_exec_out)
            2'b00: begin
                sum33    = sel_a ? ({1'b0, srcA} - {1'b0, srcB}) : ({1'b0, srcA} + {1'b0, srcB});
                exec_out = sum33[DATA_W-1:0];
            end
            2'b01: exec_out = sel_comp ? {31'd0, ($signed(srcA) < $signed(srcB))} : {31'd0, (srcA < srcB)};
            2'b10: exec_out = (sel_l == 2'b00) ? (srcA ^ srcB) : (sel_l == 2'b01) ? (srcA | srcB) : (srcA & srcB);
            default: exec_out = !sel_s[1] ? (srcA << srcB[4:0]) :
                                sel_s[0] ? DATA_W'($signed(srcA) >>> srcB[4:0]) : (srcA >> srcB[4:0]);
        endcase
    end
    assign z = (exec_out == '0);
    assign n = exec_out[DATA_W-1];
    assign c = sum33[DATA_W];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one request from IDLE; returns in DONE with latency and result checked.
    task automatic run_op(input string tag, input logic [2:0] f3, input logic f7, input logic imm,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
        bus.in_funct3   = f3;
        bus.in_funct7b5 = f7;
        bus.in_is_imm   = imm;
        bus.in_a        = a;
        bus.in_b        = b;
        bus.in_valid    = 1'b1;
        check({tag, "_rdy"}, 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
        check({tag, "_exec_nv"}, 32'(bus.out_valid), 32'd0);
        tick();
        check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
        check({tag, "_res"}, bus.out_result, exp);
    endtask

    task automatic handoff(input string tag);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        exp_cnt = exp_cnt + 4'd1;
        check({tag, "_cnt"}, 32'(op_count), 32'(exp_cnt));
        check({tag, "_idle"}, 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        bus.in_valid = 1'b0; bus.in_funct3 = 3'd0; bus.in_funct7b5 = 1'b0; bus.in_is_imm = 1'b0;
        bus.in_a = 32'd0; bus.in_b = 32'd0; bus.out_ready = 1'b0;
        exp_cnt = 4'd0;
        #12;
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_srcA", srcA, 32'd0);
        check("rst_result", bus.out_result, 32'd0);
        check("rst_count", 32'(op_count), 32'd0);
        rst_n = 1'b1;
        tick();

        run_op("add", 3'b000, 1'b0, 1'b0, 32'd1, 32'd1, 32'd2);
        check("add_z", 32'(bus.out_z), 32'd0);
        handoff("add");
        run_op("sub", 3'b000, 1'b1, 1'b0, 32'hFFFF_FFF6, 32'd9, 32'hFFFF_FFED);
        check("sub_n", 32'(bus.out_n), 32'd1);
        check("sub_sel_a", 32'(sel_a), 32'd1);
        handoff("sub");
        run_op("addi", 3'b000, 1'b1, 1'b1, 32'hFFFF_FFF6, 32'd9, 32'hFFFF_FFFF);
        check("addi_sel_a", 32'(sel_a), 32'd0);
        handoff("addi");
        run_op("sub0", 3'b000, 1'b1, 1'b0, 32'd555, 32'd555, 32'd0);
        check("sub0_z", 32'(bus.out_z), 32'd1);
        handoff("sub0");
        run_op("slt", 3'b010, 1'b0, 1'b0, 32'hF000_0000, 32'd34, 32'd1);
        check("slt_sel", {28'd0, sel_comp, sel_a, sel_exec_out}, {28'd0, 4'b1101});
        handoff("slt");
        run_op("sltu", 3'b011, 1'b0, 1'b0, 32'hF000_0000, 32'd34, 32'd0);
        check("sltu_sel", {28'd0, sel_comp, sel_a, sel_exec_out}, {28'd0, 4'b0101});
        handoff("sltu");
        run_op("sra", 3'b101, 1'b1, 1'b0, 32'hFFFF_FF80, 32'h0000_0407, 32'hFFFF_FFFF);
        check("sra_srcB", srcB, 32'd7);
        check("sra_sel", {28'd0, sel_s, sel_exec_out}, {28'd0, 4'b1111});
        handoff("sra");
        run_op("srl", 3'b101, 1'b0, 1'b0, 32'd32, 32'd5, 32'd1);
        check("srl_sel_s", 32'(sel_s), 32'd2);
        handoff("srl");
        run_op("xor", 3'b100, 1'b0, 1'b0, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'hFF00_0FF0);
        handoff("xor");
        run_op("or", 3'b110, 1'b0, 1'b0, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'hFFF0_0FFF);
        check("or_sel_l", 32'(sel_l), 32'd1);
        handoff("or");
        run_op("and", 3'b111, 1'b0, 1'b0, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'h00F0_000F);
        check("and_sel", {28'd0, sel_l, sel_exec_out}, {28'd0, 4'b1010});
        handoff("and");

        // Back-pressure: result held while a new request waits.
        run_op("bp", 3'b000, 1'b0, 1'b0, 32'd3, 32'd4, 32'd7);
        bus.in_funct3 = 3'b111; bus.in_funct7b5 = 1'b0; bus.in_is_imm = 1'b0;
        bus.in_a = 32'h0000_00FF; bus.in_b = 32'h0000_000F; bus.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_hold_res", bus.out_result, 32'd7);
            check("bp_hold_rdy", 32'(bus.in_ready), 32'd0);
            check("bp_hold_cnt", 32'(op_count), 32'(exp_cnt));
            check("bp_hold_sel", 32'(sel_exec_out), 32'd0);
        end
        bus.out_ready = 1'b1;
        #1;
        check("bp_release_rdy", 32'(bus.in_ready), 32'd1);
        tick();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        exp_cnt = exp_cnt + 4'd1;
        check("bp_release_cnt", 32'(op_count), 32'(exp_cnt));
        check("bp_new_exec", 32'(bus.out_valid), 32'd0);
        check("bp_new_sel_l", 32'(sel_l), 32'd2);
        tick();
        check("bp_new_valid", 32'(bus.out_valid), 32'd1);
        check("bp_new_res", bus.out_result, 32'h0000_000F);
        handoff("bp_new");

        // Counter wrap: 13 handoffs so far; three more roll the 4-bit count to 0.
        check("pre_wrap_cnt", 32'(op_count), 32'd13);
        for (int i = 0; i < 3; i++) begin
            run_op("wrap_op", 3'b000, 1'b0, 1'b0, 32'(i), 32'd1, 32'(i + 1));
            handoff("wrap");
        end
        check("wrap_zero", 32'(op_count), 32'd0);
        run_op("post_wrap", 3'b110, 1'b0, 1'b0, 32'd8, 32'd1, 32'd9);
        handoff("post_wrap");

        // Reset pulse while in EXEC.
        bus.in_funct3 = 3'b000; bus.in_a = 32'd10; bus.in_b = 32'd20; bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_exec_valid", 32'(bus.out_valid), 32'd0);
        check("rst_exec_rdy", 32'(bus.in_ready), 32'd1);
        check("rst_exec_cnt", 32'(op_count), 32'd0);
        #1;
        rst_n = 1'b1;
        exp_cnt = 4'd0;
        tick();
        check("rst_exec_idle", 32'(bus.out_valid), 32'd0);

        // Reset pulse while holding a result in DONE.
        run_op("pre_rst", 3'b000, 1'b0, 1'b0, 32'd5, 32'd6, 32'd11);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_done_valid", 32'(bus.out_valid), 32'd0);
        check("rst_done_res", bus.out_result, 32'd0);
        check("rst_done_cnt", 32'(op_count), 32'd0);
        #1;
        rst_n = 1'b1;
        tick();
        run_op("after_rst", 3'b000, 1'b0, 1'b0, 32'd40, 32'd2, 32'd42);
        handoff("after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
